// File: rtl/multiport_ram_pkg.sv
// Shared types and constants for the LVT-based multi-port RAM.
// Holds the init FSM state type and read-collision bit positions.
package multiport_ram_pkg;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  localparam int RDCOL_WR_BIT = 0;
  localparam int RDCOL_RD_BIT = 1;

endpackage

// File: rtl/ram_bank_1w1r.sv
// One-write one-read RAM bank with synchronous read and no reset.
// A read and write to the same address in one cycle returns old data.
module ram_bank_1w1r #(
  parameter int ADDR_WIDTH = 3,
  parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Synchronous read port, output holds when not enabled
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/multiport_ram_lvt.sv
// Multi-port RAM: grid of 1W1R banks plus a live value table.
// Optional macro MULTIPORT_RAM_WR_BYPASS_EN returns new data on read-during-write.
module multiport_ram_lvt
  import multiport_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
  parameter int DATA_WIDTH = 8,
  parameter int NB_WRAGENT = 2,
  parameter int NB_RDAGENT = 2,
  parameter int LVT_WIDTH  = (NB_WRAGENT == 1) ? 1 : $clog2(NB_WRAGENT)
) (
  input  logic                             aclk,
  input  logic                             areset,
  output logic                             ready,
  input  logic [NB_WRAGENT-1:0]            wren,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
  input  logic [NB_WRAGENT*DATA_WIDTH-1:0] wrdata,
  output logic [NB_WRAGENT-1:0]            wrcollision,
  input  logic [NB_RDAGENT-1:0]            rden,
  input  logic [NB_RDAGENT*ADDR_WIDTH-1:0] rdaddr,
  output logic [NB_RDAGENT*DATA_WIDTH-1:0] rddata,
  output logic [NB_RDAGENT-1:0]            rdvalid,
  output logic [NB_RDAGENT*2-1:0]          rdcollision
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  init;

  logic [ADDR_WIDTH-1:0] wa [NB_WRAGENT];
  logic [DATA_WIDTH-1:0] wd [NB_WRAGENT];
  logic [NB_WRAGENT-1:0] lose;
  logic [NB_WRAGENT-1:0] win;

  logic                  bwe   [NB_WRAGENT];
  logic [ADDR_WIDTH-1:0] bwaddr[NB_WRAGENT];
  logic [DATA_WIDTH-1:0] bwdata[NB_WRAGENT];
  logic [DATA_WIDTH-1:0] bank_q[NB_WRAGENT][NB_RDAGENT];

  logic [LVT_WIDTH-1:0]  lvt [RAM_DEPTH];

  logic [ADDR_WIDTH-1:0] ra      [NB_RDAGENT];
  logic [NB_RDAGENT-1:0] inr_r;
  logic [NB_RDAGENT-1:0] re;
  logic [NB_RDAGENT-1:0] wr_hit;
  logic [NB_RDAGENT-1:0] rd_hit;
  logic [LVT_WIDTH-1:0]  lvt_rd  [NB_RDAGENT];
  logic [LVT_WIDTH-1:0]  sel_q   [NB_RDAGENT];
  logic [NB_RDAGENT-1:0] oor_q;
  logic [DATA_WIDTH-1:0] rd_word;

`ifdef MULTIPORT_RAM_WR_BYPASS_EN
  logic [NB_RDAGENT-1:0] byp_hit;
  logic [DATA_WIDTH-1:0] byp_data[NB_RDAGENT];
  logic [NB_RDAGENT-1:0] byp_q;
  logic [DATA_WIDTH-1:0] bypd_q  [NB_RDAGENT];
`endif

  assign init  = (state_q == INIT);
  assign ready = (state_q == READY);

  // Init sweep state and counter
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep advances one word per cycle until the last word is cleared
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: ;
      default: state_d = INIT;
    endcase
  end

  // Write arbitration: lowest-index agent wins a shared address
  always_comb begin
    lose = '0;
    win  = '0;
    for (int i = 0; i < NB_WRAGENT; i++) begin
      wa[i] = wraddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wd[i] = wrdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int i = 0; i < NB_WRAGENT; i++) begin
      for (int j = 0; j < NB_WRAGENT; j++) begin
        if (j < i && wren[j] && wren[i] && wa[j] == wa[i])
          lose[i] = 1'b1;
      end
      win[i] = ready && wren[i] && !lose[i]
               && (32'(wa[i]) < RAM_DEPTH);
    end
  end

  // Bank write ports; agent 0 banks are shared with the clear sweep
  always_comb begin
    for (int i = 0; i < NB_WRAGENT; i++) begin
      bwe[i]    = win[i];
      bwaddr[i] = wa[i];
      bwdata[i] = wd[i];
    end
    if (init) begin
      bwe[0]    = 1'b1;
      bwaddr[0] = cnt_q;
      bwdata[0] = '0;
    end
  end

  // Live value table: cleared by the sweep, then tracks last writer
  always_ff @(posedge aclk) begin
    if (init) begin
      lvt[cnt_q] <= '0;
    end else begin
      for (int i = 0; i < NB_WRAGENT; i++) begin
        if (win[i]) lvt[wa[i]] <= LVT_WIDTH'(i);
      end
    end
  end

  for (genvar w = 0; w < NB_WRAGENT; w++) begin : g_wr
    for (genvar r = 0; r < NB_RDAGENT; r++) begin : g_rd
      ram_bank_1w1r #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
      ) u_bank (
        .clk   (aclk),
        .we    (bwe[w]),
        .waddr (bwaddr[w]),
        .wdata (bwdata[w]),
        .re    (re[r]),
        .raddr (ra[r]),
        .rdata (bank_q[w][r])
      );
    end
  end

  // Read-side lookups and collision detection
  always_comb begin
    inr_r  = '0;
    re     = '0;
    wr_hit = '0;
    rd_hit = '0;
`ifdef MULTIPORT_RAM_WR_BYPASS_EN
    byp_hit = '0;
`endif
    for (int r = 0; r < NB_RDAGENT; r++) begin
      ra[r]     = rdaddr[r*ADDR_WIDTH +: ADDR_WIDTH];
      inr_r[r]  = (32'(ra[r]) < RAM_DEPTH);
      re[r]     = ready && rden[r] && inr_r[r];
      lvt_rd[r] = inr_r[r] ? lvt[ra[r]] : '0;
`ifdef MULTIPORT_RAM_WR_BYPASS_EN
      byp_data[r] = '0;
`endif
      for (int i = NB_WRAGENT - 1; i >= 0; i--) begin
        if (wren[i] && wa[i] == ra[r]) wr_hit[r] = 1'b1;
`ifdef MULTIPORT_RAM_WR_BYPASS_EN
        if (win[i] && wa[i] == ra[r]) begin
          byp_hit[r]  = 1'b1;
          byp_data[r] = wd[i];
        end
`endif
      end
      for (int q = 0; q < NB_RDAGENT; q++) begin
        if (q != r && rden[q] && ra[q] == ra[r]) rd_hit[r] = 1'b1;
      end
    end
  end

  // Registered read select, status and collision flags
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rdvalid     <= '0;
      rdcollision <= '0;
      wrcollision <= '0;
      oor_q       <= '0;
      for (int r = 0; r < NB_RDAGENT; r++) sel_q[r] <= '0;
`ifdef MULTIPORT_RAM_WR_BYPASS_EN
      byp_q <= '0;
      for (int r = 0; r < NB_RDAGENT; r++) bypd_q[r] <= '0;
`endif
    end else begin
      wrcollision <= ready ? lose : '0;
      for (int r = 0; r < NB_RDAGENT; r++) begin
        rdvalid[r] <= ready && rden[r];
        rdcollision[r*2 + RDCOL_WR_BIT] <= 1'b0;
        rdcollision[r*2 + RDCOL_RD_BIT] <= 1'b0;
        if (ready && rden[r]) begin
          sel_q[r] <= lvt_rd[r];
          oor_q[r] <= !inr_r[r];
          rdcollision[r*2 + RDCOL_WR_BIT] <= wr_hit[r];
          rdcollision[r*2 + RDCOL_RD_BIT] <= rd_hit[r];
`ifdef MULTIPORT_RAM_WR_BYPASS_EN
          byp_q[r]  <= byp_hit[r];
          bypd_q[r] <= byp_data[r];
`endif
        end
      end
    end
  end

  // Output mux: select the bank named by the registered LVT entry
  always_comb begin
    rddata  = '0;
    rd_word = '0;
    for (int r = 0; r < NB_RDAGENT; r++) begin
      rd_word = '0;
      if (!oor_q[r]) begin
        for (int w = 0; w < NB_WRAGENT; w++) begin
          if (sel_q[r] == LVT_WIDTH'(w)) rd_word = bank_q[w][r];
        end
      end
`ifdef MULTIPORT_RAM_WR_BYPASS_EN
      if (byp_q[r]) rd_word = bypd_q[r];
`endif
      rddata[r*DATA_WIDTH +: DATA_WIDTH] = rd_word;
    end
  end

endmodule

// File: tb/tb_multiport_ram_lvt.sv
// Testbench for multiport_ram_lvt: directed scenarios plus random traffic
// against a word-level memory model.
module tb_multiport_ram_lvt;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int ND = 8;
  localparam int NW = 2;
  localparam int NR = 2;

  logic            aclk = 1'b0;
  logic            areset = 1'b1;
  logic            ready;
  logic [NW-1:0]   wren = '0;
  logic [NW*AW-1:0] wraddr = '0;
  logic [NW*DW-1:0] wrdata = '0;
  logic [NW-1:0]   wrcollision;
  logic [NR-1:0]   rden = '0;
  logic [NR*AW-1:0] rdaddr = '0;
  logic [NR*DW-1:0] rddata;
  logic [NR-1:0]   rdvalid;
  logic [NR*2-1:0] rdcollision;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 0;

  multiport_ram_lvt dut (
    .aclk        (aclk),
    .areset      (areset),
    .ready       (ready),
    .wren        (wren),
    .wraddr      (wraddr),
    .wrdata      (wrdata),
    .wrcollision (wrcollision),
    .rden        (rden),
    .rdaddr      (rdaddr),
    .rddata      (rddata),
    .rdvalid     (rdvalid),
    .rdcollision (rdcollision)
  );

  always #5 aclk = ~aclk;

  // Reference model: plain memory array, sweep length counter
  logic [DW-1:0] mem [ND];
  bit            m_ready = 0;
  int            sweep = 0;
  logic          e_ready = 0;
  logic [NR-1:0] e_rdv = '0;
  logic [NW-1:0] e_wrc = '0;
  logic [NR*2-1:0] e_rdc = '0;
  logic [DW-1:0] e_data [NR];

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_ready = 0;
      sweep = 0;
      e_ready = 0;
      e_rdv = '0;
      e_wrc = '0;
      e_rdc = '0;
      for (int a = 0; a < ND; a++) mem[a] = '0;
    end else if (!m_ready) begin
      sweep++;
      if (sweep == ND) begin
        m_ready = 1;
        e_ready = 1;
      end
    end else begin
      for (int r = 0; r < NR; r++) begin
        int a;
        a = int'(rdaddr[r*AW +: AW]);
        e_rdv[r] = rden[r];
        e_rdc[r*2] = 1'b0;
        e_rdc[r*2+1] = 1'b0;
        if (rden[r]) begin
          e_data[r] = mem[a];
          for (int i = NW - 1; i >= 0; i--) begin
            if (wren[i] && int'(wraddr[i*AW +: AW]) == a) begin
              e_rdc[r*2] = 1'b1;
`ifdef MULTIPORT_RAM_WR_BYPASS_EN
              e_data[r] = wrdata[i*DW +: DW];
`endif
            end
          end
          for (int q = 0; q < NR; q++)
            if (q != r && rden[q] && int'(rdaddr[q*AW +: AW]) == a)
              e_rdc[r*2+1] = 1'b1;
        end
      end
      for (int i = 0; i < NW; i++) begin
        e_wrc[i] = 1'b0;
        for (int j = 0; j < i; j++)
          if (wren[i] && wren[j] && wraddr[i*AW +: AW] == wraddr[j*AW +: AW])
            e_wrc[i] = 1'b1;
      end
      for (int i = NW - 1; i >= 0; i--)
        if (wren[i]) mem[int'(wraddr[i*AW +: AW])] = wrdata[i*DW +: DW];
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against model every cycle on the falling edge
  always @(negedge aclk) begin
    if (chk_en) begin
      chk("m_ready", 32'(ready), 32'(e_ready));
      chk("m_wrcollision", 32'(wrcollision), 32'(e_wrc));
      chk("m_rdvalid", 32'(rdvalid), 32'(e_rdv));
      chk("m_rdcollision", 32'(rdcollision), 32'(e_rdc));
      for (int r = 0; r < NR; r++)
        if (e_rdv[r])
          chk("m_rddata", 32'(rddata[r*DW +: DW]), 32'(e_data[r]));
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic clr();
    wren = '0;
    rden = '0;
  endtask

  task automatic wr(input int ag, input int a, input logic [7:0] d);
    wren[ag] = 1'b1;
    wraddr[ag*AW +: AW] = AW'(a);
    wrdata[ag*DW +: DW] = d;
  endtask

  task automatic rd(input int rr, input int a);
    rden[rr] = 1'b1;
    rdaddr[rr*AW +: AW] = AW'(a);
  endtask

  logic [7:0] exp_byp;

  initial begin
    areset = 1'b1;
    repeat (3) step();
    chk_en = 1;
    areset = 1'b0;
    for (int k = 0; k <= ND; k++) begin
      if (k > 0) step();
      chk("l_ready_sweep", 32'(ready), 32'(k == ND));
    end
    rd(1, 6);
    step();
    clr();
    chk("l_rd_after_init", 32'(rddata[15:8]), 32'h00);
    chk("l_rdvalid_init", 32'(rdvalid), 32'b10);

    wr(0, 3, 8'hA5);
    step();
    clr();
    rd(0, 3);
    step();
    clr();
    chk("l_rd_a5", 32'(rddata[7:0]), 32'hA5);
    wr(1, 3, 8'h5A);
    step();
    clr();
    rd(0, 3);
    step();
    clr();
    chk("l_rd_5a", 32'(rddata[7:0]), 32'h5A);

    wr(0, 5, 8'h11);
    wr(1, 5, 8'h22);
    step();
    clr();
    chk("l_wrcollision", 32'(wrcollision), 32'b10);
    rd(0, 5);
    step();
    clr();
    chk("l_wrcollision_clr", 32'(wrcollision), 32'b00);
    chk("l_rd_winner", 32'(rddata[7:0]), 32'h11);

    wr(0, 2, 8'h33);
    step();
    clr();
    wr(1, 2, 8'h77);
    rd(0, 2);
    step();
    clr();
`ifdef MULTIPORT_RAM_WR_BYPASS_EN
    exp_byp = 8'h77;
`else
    exp_byp = 8'h33;
`endif
    chk("l_rdw_data", 32'(rddata[7:0]), 32'(exp_byp));
    chk("l_rdw_col", 32'(rdcollision[1:0]), 32'b01);
    rd(0, 2);
    step();
    clr();
    chk("l_rdw_after", 32'(rddata[7:0]), 32'h77);

    wr(0, 4, 8'h9C);
    step();
    clr();
    rd(0, 4);
    rd(1, 4);
    step();
    clr();
    chk("l_rr_data", 32'(rddata), 32'h9C9C);
    chk("l_rr_col", 32'(rdcollision), 32'b1010);
    chk("l_rr_valid", 32'(rdvalid), 32'b11);

    wr(0, 3, 8'hA5);
    step();
    clr();
    wr(0, 6, 8'h01);
    wr(1, 6, 8'h02);
    rd(0, 3);
    rd(1, 3);
    step();
    clr();
    chk("l_pre_rst_valid", 32'(rdvalid), 32'b11);
    areset = 1'b1;
    #1;
    chk("l_rst_ready", 32'(ready), 32'h0);
    chk("l_rst_rdvalid", 32'(rdvalid), 32'h0);
    chk("l_rst_wrcol", 32'(wrcollision), 32'h0);
    chk("l_rst_rdcol", 32'(rdcollision), 32'h0);
    step();
    areset = 1'b0;
    for (int k = 0; k < ND; k++) begin
      wr(0, 3, 8'hFF);
      rd(1, 3);
      step();
    end
    clr();
    chk("l_ready_again", 32'(ready), 32'h1);
    rd(0, 3);
    step();
    clr();
    chk("l_rd_cleared", 32'(rddata[7:0]), 32'h00);

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NW; i++) begin
        wren[i] = 1'($urandom_range(0, 1));
        wraddr[i*AW +: AW] = AW'($urandom_range(0, (c % 2) ? 7 : 2));
        wrdata[i*DW +: DW] = DW'($urandom);
      end
      for (int r = 0; r < NR; r++) begin
        rden[r] = 1'($urandom_range(0, 1));
        rdaddr[r*AW +: AW] = AW'($urandom_range(0, (c % 3) ? 7 : 2));
      end
      if (c == 300) areset = 1'b1;
      if (c == 302) areset = 1'b0;
      step();
    end
    clr();
    step();
    step();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
